// File: rtl/reaction_timer_pkg.sv
// Shared types and default sizing for the reaction timer.
package reaction_timer_pkg;

  // Default saturation value of a reaction time, in ms
  localparam int RT_MAX_DEF = 9999;
  // Default width of every ms count (2**RT_W must exceed RT_MAX)
  localparam int RT_W_DEF   = 14;

  // Trial sequencing states
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_RND    = 3'd1,
    ST_DELAY       = 3'd2,
    ST_MEASURE     = 3'd3,
    ST_SHOW        = 3'd4,
    ST_FALSE_START = 3'd5
  } state_t;

endpackage

// File: rtl/ms_counter.sv
// Millisecond counter: clear, load, tick-gated decrement (floors at zero)
// and tick-gated increment that saturates at MAX.
module ms_counter #(
  parameter int W   = 14,
  parameter int MAX = 9999
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count; clear beats load, load beats counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else if (tick_i && inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game controller: random delay, stimulus lamp, reaction
// measurement with timeout, false-start detection and best-time tracking.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int RT_MAX = RT_MAX_DEF,
  parameter int RT_W   = RT_W_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ms_tick,
  input  logic            start,
  input  logic            stop,
  input  logic [14:0]     random,
  input  logic            rnd_ready,
  output logic            led,
  output logic [RT_W-1:0] rt_ms,
  output logic [RT_W-1:0] best_ms,
  output logic            done,
  output logic            false_start
);

  localparam logic [RT_W-1:0] RT_MAX_V  = RT_W'(RT_MAX);
  localparam logic [RT_W-1:0] RT_LAST_V = RT_W'(RT_MAX - 1);

  state_t          state_q;
  logic            led_q;
  logic            done_q;
  logic            false_start_q;
  logic [RT_W-1:0] rt_ms_q;
  logic [RT_W-1:0] best_ms_q;

  logic [RT_W-1:0] delay_cnt;
  logic [RT_W-1:0] rt_cnt;
  logic            delay_load;
  logic            delay_dec;
  logic            delay_term;
  logic            rt_clr;
  logic            rt_inc;

  // Only the low RT_W bits of the random candidate are meaningful
  if (RT_W < 15) begin : g_rnd_unused
    wire unused_rnd_bits = ^random[14:RT_W];
  end

  // A stop in WAIT_RND/DELAY is a false start and suppresses all counting
  assign delay_term = (delay_cnt <= RT_W'(1));
  assign delay_load = (state_q == ST_WAIT_RND) && rnd_ready && !stop;
  assign delay_dec  = (state_q == ST_DELAY) && !stop;
  assign rt_clr     = (state_q == ST_DELAY) && ms_tick && delay_term && !stop;
  assign rt_inc     = (state_q == ST_MEASURE) && !stop;

  ms_counter #(.W(RT_W), .MAX(RT_MAX)) u_delay_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick_i     (ms_tick),
    .clr_i      (1'b0),
    .load_i     (delay_load),
    .load_val_i (random[RT_W-1:0]),
    .dec_i      (delay_dec),
    .inc_i      (1'b0),
    .cnt_o      (delay_cnt)
  );

  ms_counter #(.W(RT_W), .MAX(RT_MAX)) u_rt_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick_i     (ms_tick),
    .clr_i      (rt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .dec_i      (1'b0),
    .inc_i      (rt_inc),
    .cnt_o      (rt_cnt)
  );

  // Trial FSM with registered lamp, result and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      led_q         <= 1'b0;
      done_q        <= 1'b0;
      false_start_q <= 1'b0;
      rt_ms_q       <= '0;
      best_ms_q     <= RT_MAX_V;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_SHOW, ST_FALSE_START: begin
          if (start) begin
            state_q       <= ST_WAIT_RND;
            false_start_q <= 1'b0;
          end
        end
        ST_WAIT_RND: begin
          if (stop) begin
            state_q       <= ST_FALSE_START;
            false_start_q <= 1'b1;
          end else if (rnd_ready) begin
            state_q <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (stop) begin
            state_q       <= ST_FALSE_START;
            false_start_q <= 1'b1;
          end else if (ms_tick && delay_term) begin
            state_q <= ST_MEASURE;
            led_q   <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (stop) begin
            state_q <= ST_SHOW;
            led_q   <= 1'b0;
            done_q  <= 1'b1;
            rt_ms_q <= rt_cnt;
            if (rt_cnt < best_ms_q) begin
              best_ms_q <= rt_cnt;
            end
          end else if (ms_tick && (rt_cnt >= RT_LAST_V)) begin
            // Timeout: report saturated time, never a best-time candidate
            state_q <= ST_SHOW;
            led_q   <= 1'b0;
            done_q  <= 1'b1;
            rt_ms_q <= RT_MAX_V;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          led_q         <= 1'b0;
          false_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign led         = led_q;
  assign done        = done_q;
  assign false_start = false_start_q;
  assign rt_ms       = rt_ms_q;
  assign best_ms     = best_ms_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: normal trials, false starts,
// timeout, coincident stop/tick cases and mid-trial reset.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ms_tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [14:0] random = '0;
  logic        rnd_ready = 1'b0;
  logic        led;
  logic [13:0] rt_ms;
  logic [13:0] best_ms;
  logic        done;
  logic        false_start;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int led_seen = 0;
  int d0;

  reaction_timer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ms_tick     (ms_tick),
    .start       (start),
    .stop        (stop),
    .random      (random),
    .rnd_ready   (rnd_ready),
    .led         (led),
    .rt_ms       (rt_ms),
    .best_ms     (best_ms),
    .done        (done),
    .false_start (false_start)
  );

  always #5 clk = ~clk;

  // Count done-high cycles and record whether the lamp ever lit
  always @(posedge clk) begin
    if (done) done_cnt = done_cnt + 1;
    if (led) led_seen = 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ms_tick = 1'b1;
      cyc();
      ms_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  // Start a trial and hand over a ready random value
  task automatic begin_trial(input int rnd);
    pulse_start();
    random = 15'(rnd);
    rnd_ready = 1'b1;
    cyc();
    rnd_ready = 1'b0;
    random = 15'd4321;
  endtask

  initial begin
    // Reset state
    cyc();
    chk("rst_led", led, 0);
    chk("rst_done", done, 0);
    chk("rst_fs", false_start, 0);
    chk("rst_rt", rt_ms, 0);
    chk("rst_best", best_ms, 9999);
    reset_n = 1'b1;
    cyc();

    // Stop in IDLE is ignored
    pulse_stop();
    cyc();
    chk("idle_stop_fs", false_start, 0);

    // Trial 1: non-ready candidate must not load, then 1500 ms delay, stop at 250
    pulse_start();
    random = 15'd4000;
    rnd_ready = 1'b0;
    cyc(); cyc(); cyc();
    random = 15'd1500;
    rnd_ready = 1'b1;
    cyc();
    rnd_ready = 1'b0;
    random = 15'd4321;
    led_seen = 0;
    d0 = done_cnt;
    ticks(1499);
    chk("t1_led_before", led_seen, 0);
    ticks(1);
    chk("t1_led_after", led, 1);
    ticks(250);
    pulse_stop();
    chk("t1_done", done, 1);
    chk("t1_rt", rt_ms, 250);
    chk("t1_best", best_ms, 250);
    chk("t1_led_off", led, 0);
    cyc();
    chk("t1_done_once", done_cnt - d0, 1);

    // Trial 2: 400 ms is not a new best; start during MEASURE ignored
    begin_trial(1000);
    ticks(1000);
    chk("t2_led", led, 1);
    ticks(200);
    pulse_start();
    ticks(200);
    chk("t2_led_hold", led, 1);
    pulse_stop();
    chk("t2_rt", rt_ms, 400);
    chk("t2_best", best_ms, 250);

    // Trial 3: false start in DELAY
    begin_trial(3000);
    led_seen = 0;
    d0 = done_cnt;
    ticks(700);
    pulse_stop();
    chk("t3_fs", false_start, 1);
    ticks(3000);
    chk("t3_led_never", led_seen, 0);
    chk("t3_no_done", done_cnt - d0, 0);
    chk("t3_rt", rt_ms, 400);
    chk("t3_best", best_ms, 250);
    pulse_start();
    chk("t3_fs_clr", false_start, 0);

    // Trial 4: timeout after 9999 ticks (already in WAIT_RND)
    random = 15'd1000;
    rnd_ready = 1'b1;
    cyc();
    rnd_ready = 1'b0;
    ticks(1000);
    chk("t4_led", led, 1);
    d0 = done_cnt;
    ticks(9998);
    chk("t4_no_done_yet", done_cnt - d0, 0);
    chk("t4_led_hold", led, 1);
    ticks(1);
    chk("t4_rt", rt_ms, 9999);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_best", best_ms, 250);
    chk("t4_led_off", led, 0);

    // Trial 5a: stop together with terminal delay tick -> false start
    begin_trial(1000);
    led_seen = 0;
    ticks(999);
    ms_tick = 1'b1;
    stop = 1'b1;
    cyc();
    ms_tick = 1'b0;
    stop = 1'b0;
    cyc();
    chk("t5a_fs", false_start, 1);
    chk("t5a_led", led_seen, 0);

    // Trial 5b: stop together with a MEASURE tick at rt_cnt=37
    begin_trial(1000);
    ticks(1000);
    ticks(37);
    d0 = done_cnt;
    ms_tick = 1'b1;
    stop = 1'b1;
    cyc();
    ms_tick = 1'b0;
    stop = 1'b0;
    chk("t5b_rt", rt_ms, 37);
    chk("t5b_best", best_ms, 37);
    cyc();
    chk("t5b_done_once", done_cnt - d0, 1);

    // Trial 6: asynchronous reset during MEASURE
    begin_trial(1000);
    ticks(1010);
    chk("t6_led", led, 1);
    d0 = done_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_led_rst", led, 0);
    chk("t6_best_rst", best_ms, 9999);
    chk("t6_rt_rst", rt_ms, 0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    ticks(20);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_led_idle", led, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
